// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer handshake bundle for sync_fifo_flags.
// master drives requests and write data; slave is the FIFO side.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  w_en;
    logic                  r_en;
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, flush, clr_err, data_in,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, flush, clr_err, data_in,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush and optional first-word-fall-through.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_flags_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_do_rd;
    logic w_do_wr;
    logic w_ovf_set;
    logic w_unf_set;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : PW'(p + 1'b1);
    endfunction

    always_comb begin
        w_full    = (r_count == FULL_CNT);
        w_empty   = (r_count == '0);
        w_do_rd   = bus.r_en & ~w_empty & ~bus.flush;
        w_do_wr   = bus.w_en & (~w_full | w_do_rd) & ~bus.flush;
        w_ovf_set = bus.w_en & ~w_do_wr & ~bus.flush;
        w_unf_set = bus.r_en & w_empty & ~bus.flush;
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_wr) r_wr_ptr <= f_next(r_wr_ptr);
                if (w_do_rd) r_rd_ptr <= f_next(r_rd_ptr);
                r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
            end
            // A coincident set condition beats clr_err.
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~bus.clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_dout <= '0;
                else if (w_do_rd) r_dout <= r_mem[r_rd_ptr];
            end
            assign bus.data_out = r_dout;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_CNT);
    assign bus.almost_empty = (r_count <= AE_CNT);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one registered-read instance and one FWFT instance.
module tb_sync_fifo_flags;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(8)) b0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(8)) b1 ();

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
        u_reg (.clk(clk), .rst_n(rst_n), .bus(b0));
    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle0();
        b0.w_en = 1'b0; b0.r_en = 1'b0; b0.flush = 1'b0; b0.clr_err = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle0();
        b0.data_in = '0;
        b1.w_en = 1'b0; b1.r_en = 1'b0; b1.flush = 1'b0; b1.clr_err = 1'b0;
        b1.data_in = '0;

        #3;
        chk("rst_count", b0.count, 0);
        chk("rst_empty", b0.empty, 1);
        chk("rst_full", b0.full, 0);
        chk("rst_ae", b0.almost_empty, 1);
        chk("rst_af", b0.almost_full, 0);
        chk("rst_ovf", b0.overflow, 0);
        chk("rst_unf", b0.underflow, 0);
        chk("rst_dout", b0.data_out, 0);
        chk("rst_fwft_dout", b1.data_out, 0);
        #4 rst_n = 1'b1;
        tick();

        // 1: fill to full, then one dropped write
        for (int i = 1; i <= 8; i++) begin
            b0.w_en = 1'b1; b0.data_in = 8'(i);
            tick();
            chk("t1_count", b0.count, i);
            chk("t1_ae", b0.almost_empty, (i <= 2) ? 1 : 0);
            chk("t1_af", b0.almost_full, (i >= 6) ? 1 : 0);
            chk("t1_full", b0.full, (i == 8) ? 1 : 0);
        end
        b0.data_in = 8'h09;
        tick();
        chk("t1_ovf", b0.overflow, 1);
        chk("t1_count_held", b0.count, 8);
        idle0();

        // 2: drain in order, then one rejected read
        for (int i = 1; i <= 8; i++) begin
            b0.r_en = 1'b1;
            tick();
            chk("t2_dout", b0.data_out, i);
            chk("t2_count", b0.count, 8 - i);
        end
        chk("t2_empty", b0.empty, 1);
        tick();
        chk("t2_unf", b0.underflow, 1);
        chk("t2_dout_held", b0.data_out, 8'h08);
        // rejected read together with clr_err: set wins
        b0.clr_err = 1'b1;
        tick();
        chk("t2_setwins_unf", b0.underflow, 1);
        chk("t2_setwins_ovf", b0.overflow, 0);
        idle0();
        b0.clr_err = 1'b1;
        tick();
        chk("t2_clr_unf", b0.underflow, 0);
        idle0();

        // 3: simultaneous read/write while full, pointers wrap
        for (int i = 1; i <= 8; i++) begin
            b0.w_en = 1'b1; b0.data_in = 8'(i);
            tick();
        end
        chk("t3_full", b0.full, 1);
        for (int i = 0; i < 4; i++) begin
            b0.w_en = 1'b1; b0.r_en = 1'b1; b0.data_in = 8'(8'hA0 + i);
            tick();
            chk("t3_rw_dout", b0.data_out, i + 1);
            chk("t3_rw_count", b0.count, 8);
            chk("t3_rw_ovf", b0.overflow, 0);
        end
        b0.w_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b0.r_en = 1'b1;
            tick();
            chk("t3_drain", b0.data_out, (i < 4) ? (5 + i) : (8'hA0 + i - 4));
        end
        chk("t3_empty", b0.empty, 1);
        // empty: simultaneous read/write accepts only the write
        b0.w_en = 1'b1; b0.r_en = 1'b1; b0.data_in = 8'h33;
        tick();
        chk("t3_e_count", b0.count, 1);
        chk("t3_e_dout", b0.data_out, 8'hA3);
        chk("t3_e_unf", b0.underflow, 1);
        b0.w_en = 1'b0;
        tick();
        chk("t3_e_read", b0.data_out, 8'h33);
        idle0();
        b0.clr_err = 1'b1;
        tick();
        idle0();

        // 4: flush priority, errors sticky across flush, clr_err
        for (int i = 1; i <= 3; i++) begin
            b0.w_en = 1'b1; b0.data_in = 8'(8'h10 * i + i);
            tick();
        end
        chk("t4_count3", b0.count, 3);
        b0.flush = 1'b1; b0.data_in = 8'h44;
        tick();
        chk("t4_fl_count", b0.count, 0);
        chk("t4_fl_empty", b0.empty, 1);
        chk("t4_fl_ovf", b0.overflow, 0);
        chk("t4_fl_dout", b0.data_out, 8'h33);
        b0.w_en = 1'b0; b0.r_en = 1'b1;
        tick();
        chk("t4_fl_unf", b0.underflow, 0);
        b0.flush = 1'b0;
        tick();
        chk("t4_unf_set", b0.underflow, 1);
        b0.r_en = 1'b0; b0.flush = 1'b1;
        tick();
        chk("t4_unf_sticky", b0.underflow, 1);
        idle0();
        b0.clr_err = 1'b1;
        tick();
        chk("t4_clr_unf", b0.underflow, 0);
        chk("t4_clr_ovf", b0.overflow, 0);
        idle0();

        // 5: FWFT head presentation
        b1.w_en = 1'b1; b1.data_in = 8'h5A;
        tick();
        chk("t5_head", b1.data_out, 8'h5A);
        b1.data_in = 8'h5B;
        tick();
        chk("t5_head_hold", b1.data_out, 8'h5A);
        b1.w_en = 1'b0; b1.r_en = 1'b1;
        tick();
        chk("t5_pop", b1.data_out, 8'h5B);
        tick();
        chk("t5_empty", b1.empty, 1);
        chk("t5_dout0", b1.data_out, 0);
        b1.r_en = 1'b0;

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            b0.w_en = 1'b1; b0.data_in = 8'(8'h61 + i);
            tick();
        end
        b0.w_en = 1'b0; b0.r_en = 1'b1;
        tick();
        chk("t6_pre_dout", b0.data_out, 8'h61);
        b0.r_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_count", b0.count, 0);
        chk("t6_empty", b0.empty, 1);
        chk("t6_full", b0.full, 0);
        chk("t6_ae", b0.almost_empty, 1);
        chk("t6_af", b0.almost_full, 0);
        chk("t6_ovf", b0.overflow, 0);
        chk("t6_unf", b0.underflow, 0);
        chk("t6_dout", b0.data_out, 0);
        #1 rst_n = 1'b1;
        b0.w_en = 1'b1; b0.data_in = 8'h77;
        tick();
        chk("t6_w_count", b0.count, 1);
        b0.w_en = 1'b0; b0.r_en = 1'b1;
        tick();
        chk("t6_r_dout", b0.data_out, 8'h77);
        chk("t6_r_empty", b0.empty, 1);
        idle0();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO: the next generation of the team's `synchronous_fifo`, sitting between a producer and a consumer in the same clock domain. Adds the following to the plain full/empty FIFO:
- programmable almost-full/almost-empty thresholds;
- an occupancy count;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode.

The existing layered testbench (intf/env/test_lib) drives it with the same write/read handshake.

## Interface
- DATA_WIDTH, 8, width of each entry
- DEPTH, 8, number of entries; any integer ≥ 2, not restricted to powers of two
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- FWFT, 0, read mode:
  - 0 = registered read;
  - 1 = head entry presented on data_out without a read request
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- w_en  in  1  write request
- r_en  in  1  read request
- flush  in  1  synchronous clear of contents
- clr_err  in  1  synchronous clear of the sticky error flags
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was rejected

## Operation
- **Storage:** DEPTH × DATA_WIDTH array, not reset.
- **Pointers:** wr_ptr and rd_ptr range 0..DEPTH-1; each wraps from DEPTH-1 to 0 explicitly, with no reliance on power-of-two rollover.
- **Accept conditions:**
  - do_wr = w_en & (!full | do_rd);
  - do_rd = r_en & !empty.
  - When full, a simultaneous read and write are both accepted and count is unchanged.
  - When empty, a simultaneous read and write accept only the write.
- **Count update:** count += do_wr − do_rd. count is a register; every flag is decoded from the registered count.
- **Errors:**
  - overflow sets on w_en & !do_wr.
  - underflow sets on r_en & empty.
  - Both are sticky until clr_err or reset.
  - If a set condition and clr_err coincide, the set wins.
- **Flush:**
  - Has priority over w_en and r_en in the same cycle; both requests are ignored and no error is flagged for them.
  - Sets wr_ptr = rd_ptr = 0 and count = 0.
  - Does not alter overflow, underflow or the stored data.
- **FWFT = 0:** on do_rd, data_out <= mem[rd_ptr]. Otherwise data_out holds its last value, including across empty and flush.
- **FWFT = 1:**
  - data_out = mem[rd_ptr] whenever !empty, and 0 when empty.
  - do_rd pops the head, and data_out shows the next entry combinationally after that edge.

## Timing
- **Reset (rst_n low, asynchronous):**
  - count = 0, pointers = 0;
  - empty = 1, full = 0;
  - almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), which is always 0 for legal AF_LEVEL;
  - overflow = 0, underflow = 0, data_out = 0.
- Reset mid-operation discards all contents immediately. The first edge after deassertion behaves as for an empty FIFO.
- **Write-to-flag latency:** 1 cycle. A write at edge N makes empty = 0 and count = 1 after edge N.
- **Write-to-read latency:**
  - FWFT = 0: the earliest read is at edge N+1, with data valid after edge N+1 (read latency 1).
  - FWFT = 1: data_out is valid immediately after edge N (0 read latency from the visible head).
- **Error-flag timing:** overflow and underflow assert after the edge that sampled the offending request.
- **Flag updates:** full, almost_full, almost_empty and count update together after each edge. There are no combinational paths from w_en or r_en to any flag.
- **Handshake:** requests are single-cycle samples. Holding w_en for K cycles attempts K writes.

## Test plan
Unless noted, DATA_WIDTH = 8, DEPTH = 8, AF_LEVEL = 6, AE_LEVEL = 2, FWFT = 0.
1. Reset, then write 0x01..0x08 on 8 consecutive cycles:
   - almost_empty drops after the 3rd write;
   - almost_full rises after the 6th;
   - full = 1 and count = 8 after the 8th;
   - a 9th write of 0x09 sets overflow = 1 and leaves count = 8.
2. From full, read 8 times: data_out = 0x01..0x08 in order, each one cycle after its r_en edge. empty = 1 after the 8th read. A 9th read sets underflow = 1 and data_out holds 0x08.
3. Full FIFO, w_en = r_en = 1 for 4 cycles with data 0xA0..0xA3:
   - count stays 8 and no overflow is flagged;
   - the reads return 0x01..0x04;
   - pointers wrap correctly, and later drains return 0x05..0x08 then 0xA0..0xA3.
4. Write 3 entries, then assert flush together with w_en:
   - count = 0, empty = 1, no overflow;
   - assert clr_err: overflow and underflow return to 0.
5. FWFT = 1:
   - write 0x5A: data_out = 0x5A the cycle after, with no r_en;
   - write 0x5B, then r_en: data_out = 0x5B after that edge;
   - r_en again: empty = 1 and data_out = 0.
6. Write 5 entries, then pull rst_n low between clock edges: all outputs reach their reset values without a clock edge. After release, a write of 0x77 followed by a read returns 0x77.
